// File: rtl/adc_sample_averager_pkg.sv
// Shared types and helpers for the ADC sample averager: FSM states,
// default sample width, offset-binary conversion and saturating negation.
package adc_pkg;

    localparam int WIRE_WIDTH_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Offset binary becomes two's complement by flipping the sample MSB.
    function automatic logic [31:0] offset_to_twos(input logic [31:0] raw, input int width);
        return raw ^ (32'd1 << (width - 1));
    endfunction

    // The most negative code has no positive twin, so it clamps to full scale.
    function automatic logic signed [31:0] sat_negate(input logic signed [31:0] x, input int width);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< (width - 1));
        if (x == min_v) begin
            return -x - 32'sd1;
        end
        return -x;
    endfunction

endpackage

// File: rtl/adc_sample_averager_if.sv
// Handshake bundle between the ADC pins / SPGD controller and the averager.
interface adc_sample_averager_if #(
    parameter int WIRE_WIDTH = 14
);
    logic [WIRE_WIDTH-1:0] adc_in;
    logic                  adc_valid;
    logic                  start;
    logic                  busy;
    logic [WIRE_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;

    modport master (
        output adc_in, adc_valid, start, data_ready,
        input  busy, data_out, data_valid
    );

    modport slave (
        input  adc_in, adc_valid, start, data_ready,
        output busy, data_out, data_valid
    );
endinterface

// File: rtl/adc_sample_averager_offset_to_twos.sv
// Registered input stage: offset binary to two's complement, optionally
// negated with saturation when ADC_INVERT_EN is defined.
module adc_offset_to_twos
    import adc_pkg::*;
#(
    parameter int WIRE_WIDTH = WIRE_WIDTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIRE_WIDTH-1:0]        adc_i,
    input  logic                         adc_valid_i,
    input  logic                         accum_en_i,
    output logic signed [WIRE_WIDTH-1:0] s_data_o,
    output logic                         s_valid_o
);

    logic signed [WIRE_WIDTH-1:0] conv;
    logic signed [WIRE_WIDTH-1:0] s_data_q;
    logic                         s_valid_q;

    always_comb begin
`ifdef ADC_INVERT_EN
        conv = WIRE_WIDTH'(sat_negate(32'(signed'(WIRE_WIDTH'(offset_to_twos(32'(adc_i), WIRE_WIDTH)))), WIRE_WIDTH));
`else
        conv = WIRE_WIDTH'(offset_to_twos(32'(adc_i), WIRE_WIDTH));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_data_q  <= '0;
            s_valid_q <= 1'b0;
        end else begin
            s_data_q  <= conv;
            s_valid_q <= adc_valid_i && accum_en_i;
        end
    end

    assign s_data_o  = s_data_q;
    assign s_valid_o = s_valid_q;

endmodule

// File: rtl/adc_sample_averager.sv
// Averages a burst of 2^AVG_LOG2 converted ADC samples per start request and
// returns the floor-rounded mean over valid/ready. Option: ADC_INVERT_EN.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int WIRE_WIDTH = WIRE_WIDTH_DEFAULT,
    parameter int AVG_LOG2   = 4
) (
    input logic                  clk,
    input logic                  rst,
    adc_sample_averager_if.slave bus
);

    localparam int ACC_W = WIRE_WIDTH + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int N     = 1 << AVG_LOG2;

    state_e                       state_q, state_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic signed [WIRE_WIDTH-1:0] data_out_q, data_out_d;
    logic                         data_valid_q, data_valid_d;
    logic                         busy_q, busy_d;
    logic signed [WIRE_WIDTH-1:0] s_data;
    logic                         s_valid;
    logic signed [ACC_W-1:0]      sum;

    adc_offset_to_twos #(
        .WIRE_WIDTH(WIRE_WIDTH)
    ) u_input (
        .clk        (clk),
        .rst        (rst),
        .adc_i      (bus.adc_in),
        .adc_valid_i(bus.adc_valid),
        .accum_en_i (state_q == ACCUM),
        .s_data_o   (s_data),
        .s_valid_o  (s_valid)
    );

    // Next-state logic; the final sample is folded in directly when computing the mean.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        sum          = acc_q + ACC_W'(s_data);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (s_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        data_out_d   = WIRE_WIDTH'(sum >>> AVG_LOG2);
                        data_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (data_valid_q && bus.data_ready) begin
                    data_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager (WIRE_WIDTH=14, AVG_LOG2=4); expected
// values follow the ADC_INVERT_EN setting of the build.
module tb_adc_sample_averager;

    typedef struct {
        logic [13:0] a;
        logic [13:0] b;
        logic [13:0] expected;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[7];

`ifdef ADC_INVERT_EN
    localparam logic [13:0] EXP_2100 = 14'h3F00;
    localparam logic [13:0] EXP_3FFF = 14'h2001;
`else
    localparam logic [13:0] EXP_2100 = 14'h0100;
    localparam logic [13:0] EXP_3FFF = 14'h1FFF;
`endif

    adc_sample_averager_if #(.WIRE_WIDTH(14)) bus ();

    adc_sample_averager #(
        .WIRE_WIDTH(14),
        .AVG_LOG2  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One burst: alternating samples a/b, optional adc_valid gaps, optional stray start.
    task automatic applyStimulus(input logic [13:0] a, input logic [13:0] b, input bit gapped,
                                 input int startPulseEdge, input bit readyLow, output int doneEdge);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.adc_valid  = !gapped;
        bus.adc_in     = b;
        bus.data_ready = !readyLow;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
        doneEdge = -1;
        for (int k = 1; k <= 200 && doneEdge < 0; k++) begin
            bus.adc_in    = k[0] ? a : b;
            bus.adc_valid = gapped ? ~k[0] : 1'b1;
            bus.start     = (k == startPulseEdge);
            @(negedge clk);
            if (bus.data_valid) doneEdge = k;
        end
        bus.start = 1'b0;
    endtask

    initial begin
        int done;

`ifdef ADC_INVERT_EN
        vecs[0] = '{14'h3FFF, 14'h3FFF, 14'h2001};
        vecs[1] = '{14'h0000, 14'h0000, 14'h1FFF};
        vecs[2] = '{14'h2000, 14'h2000, 14'h0000};
        vecs[3] = '{14'h1FFF, 14'h2000, 14'h0000};
        vecs[4] = '{14'h2001, 14'h2000, 14'h3FFF};
        vecs[5] = '{14'h3000, 14'h1000, 14'h0000};
        vecs[6] = '{14'h2100, 14'h2100, 14'h3F00};
`else
        vecs[0] = '{14'h3FFF, 14'h3FFF, 14'h1FFF};
        vecs[1] = '{14'h0000, 14'h0000, 14'h2000};
        vecs[2] = '{14'h2000, 14'h2000, 14'h0000};
        vecs[3] = '{14'h1FFF, 14'h2000, 14'h3FFF};
        vecs[4] = '{14'h2001, 14'h2000, 14'h0000};
        vecs[5] = '{14'h3000, 14'h1000, 14'h0000};
        vecs[6] = '{14'h2100, 14'h2100, 14'h0100};
`endif

        rst            = 1'b1;
        bus.adc_in     = '0;
        bus.adc_valid  = 1'b0;
        bus.start      = 1'b0;
        bus.data_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_data_valid", 32'(bus.data_valid), 32'd0);
        checkOutput("reset_data_out", 32'(bus.data_out), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, 1'b0, -1, 1'b0, done);
            checkOutput($sformatf("vec%0d_latency", i), 32'(done), 32'd17);
            checkOutput($sformatf("vec%0d_data_out", i), 32'(bus.data_out), 32'(vecs[i].expected));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_valid_dropped", i), 32'(bus.data_valid), 32'd0);
            checkOutput($sformatf("vec%0d_busy_dropped", i), 32'(bus.busy), 32'd0);
            checkOutput($sformatf("vec%0d_data_kept", i), 32'(bus.data_out), 32'(vecs[i].expected));
        end

        $display("[TB] gapped adc_valid with start during ACCUM");
        applyStimulus(14'h2100, 14'h2100, 1'b1, 5, 1'b0, done);
        checkOutput("gapped_latency", 32'(done), 32'd33);
        checkOutput("gapped_data_out", 32'(bus.data_out), 32'(EXP_2100));
        @(negedge clk);
        checkOutput("gapped_busy_dropped", 32'(bus.busy), 32'd0);

        $display("[TB] data_ready stall in HOLD with stray starts");
        applyStimulus(14'h3FFF, 14'h3FFF, 1'b0, -1, 1'b1, done);
        checkOutput("stall_latency", 32'(done), 32'd17);
        for (int c = 0; c < 10; c++) begin
            bus.start = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("stall%0d_valid", c), 32'(bus.data_valid), 32'd1);
            checkOutput($sformatf("stall%0d_data_out", c), 32'(bus.data_out), 32'(EXP_3FFF));
            checkOutput($sformatf("stall%0d_busy", c), 32'(bus.busy), 32'd1);
        end
        bus.data_ready = 1'b1;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("stall_handshake_valid", 32'(bus.data_valid), 32'd0);
        checkOutput("stall_handshake_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput("stall_start_ignored", 32'(bus.busy), 32'd0);
        checkOutput("stall_data_kept", 32'(bus.data_out), 32'(EXP_3FFF));

        $display("[TB] reset mid-ACCUM");
        bus.start     = 1'b1;
        bus.adc_valid = 1'b1;
        bus.adc_in    = 14'h3FFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
        checkOutput("midreset_data_valid", 32'(bus.data_valid), 32'd0);
        checkOutput("midreset_data_out", 32'(bus.data_out), 32'd0);
        applyStimulus(14'h2100, 14'h2100, 1'b0, -1, 1'b0, done);
        checkOutput("postreset_latency", 32'(done), 32'd17);
        checkOutput("postreset_data_out", 32'(bus.data_out), 32'(EXP_2100));
        @(negedge clk);
        checkOutput("postreset_valid_dropped", 32'(bus.data_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
